// File: rtl/my_bin2bcd_pkg.sv
// Shared definitions for the my_bin2bcd converter: FSM states, BCD code points
// and the per-digit add-3 correction used by the shift-add-3 algorithm.
package my_bin2bcd_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_NINE  = 4'h9;

    function automatic logic [3:0] add3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage

// File: rtl/my_bcd_digit_adj.sv
// One BCD digit correction stage: adds 3 when the digit is 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module my_bcd_digit_adj
    import my_bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = add3(digit);

endmodule

// File: rtl/my_bin2bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-add-3).
// Optional build macro MY_BIN2BCD_BLANK_EN replaces leading-zero digits with 4'hF.
module my_bin2bcd
    import my_bin2bcd_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_bin,
    output logic           out_valid,
    output logic [4*D-1:0] out_bcd,
    output logic           out_ovf
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     shift_reg;
    logic [4*D-1:0]   bcd_acc;
    logic [4*D-1:0]   bcd_adj;
    logic [4*D-1:0]   bcd_shifted;
    logic [4*D-1:0]   bcd_final;
    logic             ovf_acc;
    logic             ovf_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             last_bit;
`ifdef MY_BIN2BCD_BLANK_EN
    logic             leading;
`endif

    for (genvar i = 0; i < D; i++) begin : g_adj
        my_bcd_digit_adj u_adj (
            .digit    (bcd_acc[4*i +: 4]),
            .adjusted (bcd_adj[4*i +: 4])
        );
    end

    // A 1 pushed out of the top digit means the value has passed 10^D-1.
    assign bcd_shifted = {bcd_adj[4*D-2:0], shift_reg[W-1]};
    assign ovf_next    = ovf_acc | bcd_adj[4*D-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt == '0) begin
                    last_bit   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bcd_final = bcd_shifted;
`ifdef MY_BIN2BCD_BLANK_EN
        leading = 1'b1;
`endif
        if (ovf_next) begin
            bcd_final = {D{BCD_NINE}};
        end else begin
`ifdef MY_BIN2BCD_BLANK_EN
            // Digit 0 is left alone so a zero value still shows a single 0.
            for (int i = D - 1; i >= 1; i--) begin
                if (leading && (bcd_shifted[4*i +: 4] == 4'd0)) begin
                    bcd_final[4*i +: 4] = BCD_BLANK;
                end else begin
                    leading = 1'b0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bcd_acc   <= '0;
            ovf_acc   <= 1'b0;
            bit_cnt   <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                shift_reg <= in_bin;
                bcd_acc   <= '0;
                ovf_acc   <= 1'b0;
                bit_cnt   <= CNT_LAST;
            end else if (state == S_SHIFT) begin
                shift_reg <= shift_reg << 1;
                bcd_acc   <= bcd_shifted;
                ovf_acc   <= ovf_next;
                bit_cnt   <= bit_cnt - CNT_W'(1);
                if (last_bit) begin
                    out_bcd   <= bcd_final;
                    out_ovf   <= ovf_next;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_my_bin2bcd.sv
// Self-checking bench for my_bin2bcd (W=16, D=4): directed conversions with a
// decimal reference model feeding a result scoreboard.
module tb_my_bin2bcd;

    localparam int W = 16;
    localparam int D = 4;

    typedef struct packed {
        logic [4*D-1:0] bcd;
        logic           ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_bin;
    logic           out_valid;
    logic [4*D-1:0] out_bcd;
    logic           out_ovf;

    exp_t           sb_q[$];
    exp_t           mon_e;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             accept_cyc = 0;
    logic           prev_valid = 1'b0;
    logic [4*D-1:0] prev_bcd = '0;

    my_bin2bcd #(.W(W), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference built from decimal arithmetic, independent of shift-add-3.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned r;
        int unsigned limit;
`ifdef MY_BIN2BCD_BLANK_EN
        bit          lead;
`endif
        limit = 1;
        for (int i = 0; i < D; i++) limit = limit * 10;
        if (v > limit - 1) begin
            e.bcd = {D{4'h9}};
            e.ovf = 1'b1;
            return e;
        end
        e.ovf = 1'b0;
        r = v;
        for (int i = 0; i < D; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef MY_BIN2BCD_BLANK_EN
        lead = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
            if (lead && (e.bcd[4*i +: 4] == 4'd0)) e.bcd[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return e;
    endfunction

    // Scoreboard: every out_valid pops one expected result; out_bcd must hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_output("result_bcd", 32'(out_bcd), 32'(mon_e.bcd));
                    check_output("result_ovf", 32'(out_ovf), 32'(mon_e.ovf));
                end
                check_output("valid_single_cycle", 32'(prev_valid), 32'd0);
            end else begin
                check_output("bcd_hold", 32'(out_bcd), 32'(prev_bcd));
            end
        end
        prev_valid = out_valid;
        prev_bcd   = out_bcd;
    end

    task automatic apply_stimulus(input int unsigned v, input bit keep_valid, input bit expect_result);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = W'(v);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("accept_wait_bound", 32'(n < 100), 32'd1);
        if (expect_result) sb_q.push_back(model(v));
        accept_cyc = cyc;
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_bound", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busy;
        int seen;
        int a1;
        int a2;
        int a3;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bin   = '0;
        repeat (2) @(negedge clk);
        check_output("reset_ready", 32'(in_ready), 32'd1);
        check_output("reset_valid", 32'(out_valid), 32'd0);
        check_output("reset_bcd", 32'(out_bcd), 32'd0);
        check_output("reset_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;

        $display("[TB] test 1: 1234 latency and busy window");
        apply_stimulus(1234, 1'b0, 1'b1);
        busy = 0;
        seen = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (!in_ready) busy++;
            if (out_valid) seen++;
        end
        check_output("t1_busy_cycles", 32'(busy), 32'd16);
        check_output("t1_early_valid", 32'(seen), 32'd0);
        @(negedge clk);
        check_output("t1_latency_valid", 32'(out_valid), 32'd1);
        check_output("t1_ready_after", 32'(in_ready), 32'd1);
        wait_drain();

        $display("[TB] test 2/3: zero, small, and overflow boundaries");
        apply_stimulus(0, 1'b0, 1'b1);
        wait_drain();
        apply_stimulus(7, 1'b0, 1'b1);
        wait_drain();
        apply_stimulus(9999, 1'b0, 1'b1);
        wait_drain();
        apply_stimulus(10000, 1'b0, 1'b1);
        wait_drain();
        apply_stimulus(65535, 1'b0, 1'b1);
        wait_drain();
        apply_stimulus(205, 1'b0, 1'b1);
        wait_drain();

        $display("[TB] test 4: in_valid held high, back-to-back words");
        apply_stimulus(1, 1'b1, 1'b1);
        a1 = accept_cyc;
        apply_stimulus(2, 1'b1, 1'b1);
        a2 = accept_cyc;
        apply_stimulus(3, 1'b0, 1'b1);
        a3 = accept_cyc;
        check_output("t4_spacing_12", 32'(a2 - a1), 32'd17);
        check_output("t4_spacing_23", 32'(a3 - a2), 32'd17);
        wait_drain();

        $display("[TB] test 5: in_bin changes during conversion");
        apply_stimulus(4321, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        in_bin = 16'd1111;
        repeat (4) @(negedge clk);
        in_bin = 16'd9876;
        wait_drain();

        $display("[TB] test 6: reset in the middle of a conversion");
        apply_stimulus(555, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("t6_abort_ready", 32'(in_ready), 32'd1);
        check_output("t6_abort_valid", 32'(out_valid), 32'd0);
        check_output("t6_abort_bcd", 32'(out_bcd), 32'd0);
        check_output("t6_abort_ovf", 32'(out_ovf), 32'd0);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_output("t6_no_late_valid", 32'(sb_q.size()), 32'd0);
        apply_stimulus(42, 1'b0, 1'b1);
        wait_drain();
        apply_stimulus(8000, 1'b0, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
